// File: rtl/kbd_buffer_pkg.sv
// Shared constants and helpers for the keyboard scan-code buffer.
package kbd_buffer_pkg;

    // Default CPU I/O port addresses
    localparam logic [15:0] PORT_DATA_DEF = 16'h0060;
    localparam logic [15:0] PORT_STAT_DEF = 16'h0064;

    // Status byte bit positions
    localparam int STAT_NE  = 0;
    localparam int STAT_OVF = 5;

    // PS/2 prefix bytes
    localparam logic [7:0] PFX_BREAK = 8'hF0;
    localparam logic [7:0] PFX_EXT   = 8'hE0;

    // Fold a pending break prefix into bit 7 of a scan code; the extended
    // prefix passes through untouched.
    function automatic logic [7:0] fold_byte(input logic [7:0] data, input logic brk);
        if (data == PFX_EXT) begin
            return data;
        end
        return {data[7] | brk, data[6:0]};
    endfunction

endpackage

// File: rtl/kbd_buffer_if.sv
// Keyboard receiver / CPU port / interrupt-controller signal bundle.
interface kbd_buffer_if;
    logic [7:0]  ps2_data;
    logic        ps2_hit;
    logic [15:0] port;
    logic        port_rd;
    logic [7:0]  port_o;
    logic        irq_ack;
    logic        irq_kbd;
    logic        overflow;

    // Environment side: drives receiver bytes, port accesses and acks
    modport master (
        output ps2_data, ps2_hit, port, port_rd, irq_ack,
        input  port_o, irq_kbd, overflow
    );

    // Buffer side
    modport slave (
        input  ps2_data, ps2_hit, port, port_rd, irq_ack,
        output port_o, irq_kbd, overflow
    );
endinterface

// File: rtl/kbd_buffer_sync_fifo.sv
// Single-clock FIFO with combinational head output and occupancy count.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign do_push = push && (!full || do_pop);

    // Storage write; contents are not reset, pointers alone define validity
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/kbd_buffer.sv
// PS/2 scan-code buffer: folds break prefixes, queues bytes for the CPU,
// decodes the data/status ports and raises a keyboard interrupt.
module kbd_buffer
    import kbd_buffer_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [15:0] PORT_DATA = PORT_DATA_DEF,
    parameter logic [15:0] PORT_STAT = PORT_STAT_DEF
) (
    input  logic         clock,
    input  logic         reset,
    kbd_buffer_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          break_flag;
    logic          in_service;
    logic [7:0]    hold;
    logic          overflow_flag;
    logic          irq;

    logic [7:0]    head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    logic          not_empty;
    logic          is_data;
    logic          is_stat;
    logic          is_break;
    logic          push;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic          not_empty_next;
    logic          in_service_next;
    logic [7:0]    push_data;
    logic [7:0]    status;

    assign not_empty = !empty;
    assign is_data   = (bus.port == PORT_DATA);
    assign is_stat   = (bus.port == PORT_STAT);
    assign is_break  = bus.ps2_hit && (bus.ps2_data == PFX_BREAK);
    assign push      = bus.ps2_hit && !is_break;
    assign push_data = fold_byte(bus.ps2_data, break_flag);
    assign pop       = bus.port_rd && is_data && not_empty;
    assign push_ok   = push && (!full || pop);
    assign drop      = push && full && !pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Status byte: only the not-empty and overflow bits are ever set
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_status
            if (gi == STAT_NE) begin : g_ne
                assign status[gi] = not_empty;
            end else if (gi == STAT_OVF) begin : g_ovf
                assign status[gi] = overflow_flag;
            end else begin : g_zero
                assign status[gi] = 1'b0;
            end
        end
    endgenerate

    // Post-edge occupancy and service state, so the interrupt reflects this edge's updates
    always_comb begin
        not_empty_next  = push_ok || (not_empty && !(pop && (count == CW'(1))));
        in_service_next = in_service;
        if (bus.irq_ack) begin
            in_service_next = 1'b1;
        end
        if (pop) begin
            in_service_next = 1'b0;
        end
    end

    // Prefix tracking, overflow, hold register, service state and interrupt
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            break_flag    <= 1'b0;
            in_service    <= 1'b0;
            hold          <= 8'h00;
            overflow_flag <= 1'b0;
            irq           <= 1'b0;
        end else begin
            if (is_break) begin
                break_flag <= 1'b1;
            end else if (push && (bus.ps2_data != PFX_EXT)) begin
                break_flag <= 1'b0;
            end
            // A drop on the same edge as a status read wins: the new event is not lost
            if (drop) begin
                overflow_flag <= 1'b1;
            end else if (bus.port_rd && is_stat) begin
                overflow_flag <= 1'b0;
            end
            if (pop) begin
                hold <= head;
            end
            in_service <= in_service_next;
            irq        <= not_empty_next && !in_service_next;
        end
    end

    // Combinational port read mux
    always_comb begin
        bus.port_o = 8'hFF;
        if (is_data) begin
            bus.port_o = not_empty ? head : hold;
        end else if (is_stat) begin
            bus.port_o = status;
        end
    end

    assign bus.irq_kbd  = irq;
    assign bus.overflow = overflow_flag;
endmodule
